// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the hazard/branch/MDU event sources and the pipeline stall controller.
// Inputs are event requests into the controller; outputs are stage enables, flushes and status.
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             Hazard;
    logic             Branch_Taken;
    logic             mdu_busy;
    logic             halt_req;
    logic             resume;

    logic             PC_En;
    logic             IFID_En;
    logic             IFID_Flush;
    logic             IDEX_En;
    logic             IDEX_Flush;
    logic             EXMEM_Flush;
    logic             Halted;
    logic             stall_timeout;
    logic [CNT_W-1:0] hz_cnt;
    logic [CNT_W-1:0] mdu_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output Hazard, Branch_Taken, mdu_busy, halt_req, resume,
        input  PC_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush, EXMEM_Flush,
        input  Halted, stall_timeout, hz_cnt, mdu_cnt, flush_cnt
    );

    modport slave (
        input  Hazard, Branch_Taken, mdu_busy, halt_req, resume,
        output PC_En, IFID_En, IFID_Flush, IDEX_En, IDEX_Flush, EXMEM_Flush,
        output Halted, stall_timeout, hz_cnt, mdu_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: prioritises halt, MDU, RAW hazard and
// taken-branch events into stage enables/flushes, tracks halt state, counts stalls and watches for stuck hazards.
module pipe_stall_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);
    localparam int RUN_W = $clog2(MAX_STALL + 1);

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NORMAL,
        C_BRANCH,
        C_HAZARD,
        C_MDU,
        C_FROZEN
    } cond_t;

    state_t           state_q, state_d;
    cond_t            cond;
    logic [CNT_W-1:0] hz_cnt_q, hz_cnt_d;
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    // A hazard alongside a taken branch means stale branch operands, so the hazard wins.
    always_comb begin
        cond = C_NORMAL;
        if (state_q == HALT || bus.halt_req) begin
            cond = C_FROZEN;
        end else if (bus.mdu_busy) begin
            cond = C_MDU;
        end else if (bus.Hazard) begin
            cond = C_HAZARD;
        end else if (bus.Branch_Taken) begin
            cond = C_BRANCH;
        end
    end

    always_comb begin
        bus.PC_En       = 1'b0;
        bus.IFID_En     = 1'b0;
        bus.IFID_Flush  = 1'b0;
        bus.IDEX_En     = 1'b0;
        bus.IDEX_Flush  = 1'b0;
        bus.EXMEM_Flush = 1'b0;
        if (!rst) begin
            case (cond)
                C_NORMAL: begin
                    bus.PC_En   = 1'b1;
                    bus.IFID_En = 1'b1;
                    bus.IDEX_En = 1'b1;
                end
                C_BRANCH: begin
                    bus.PC_En      = 1'b1;
                    bus.IFID_En    = 1'b1;
                    bus.IDEX_En    = 1'b1;
                    bus.IFID_Flush = 1'b1;
                end
                C_HAZARD: begin
                    bus.IDEX_En    = 1'b1;
                    bus.IDEX_Flush = 1'b1;
                end
                C_MDU: begin
                    bus.EXMEM_Flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.halt_req) state_d = HALT;
            HALT:    if (bus.resume)   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Counters saturate at all-ones; the hazard run length is frozen while halted.
    always_comb begin
        hz_cnt_d    = hz_cnt_q;
        mdu_cnt_d   = mdu_cnt_q;
        flush_cnt_d = flush_cnt_q;
        run_d       = run_q;
        if (cond == C_HAZARD && hz_cnt_q != '1)    hz_cnt_d    = hz_cnt_q + CNT_W'(1);
        if (cond == C_MDU && mdu_cnt_q != '1)      mdu_cnt_d   = mdu_cnt_q + CNT_W'(1);
        if (cond == C_BRANCH && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (state_q == RUN) begin
            if (cond == C_HAZARD) begin
                if (run_q != RUN_W'(MAX_STALL)) run_d = run_q + RUN_W'(1);
            end else begin
                run_d = '0;
            end
        end
        timeout_d = timeout_q | (run_d == RUN_W'(MAX_STALL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            hz_cnt_q    <= '0;
            mdu_cnt_q   <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hz_cnt_q    <= hz_cnt_d;
            mdu_cnt_q   <= mdu_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.Halted        = (state_q == HALT);
    assign bus.stall_timeout = timeout_q;
    assign bus.hz_cnt        = hz_cnt_q;
    assign bus.mdu_cnt       = mdu_cnt_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (32-bit/16-cycle and 4-bit/4-cycle) share stimulus;
// directed scenarios use fixed expectations, random traffic is checked against an event-level model.
module tb_pipe_stall_ctrl;
    localparam logic [5:0] NORM = 6'b110100;
    localparam logic [5:0] HZ   = 6'b000110;
    localparam logic [5:0] BR   = 6'b111100;
    localparam logic [5:0] MDU  = 6'b000001;
    localparam logic [5:0] FRZ  = 6'b000000;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_stall_ctrl_if #(.CNT_W(32)) if_a ();
    pipe_stall_ctrl_if #(.CNT_W(4))  if_b ();

    pipe_stall_ctrl #(.CNT_W(32), .MAX_STALL(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    pipe_stall_ctrl #(.CNT_W(4),  .MAX_STALL(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: index 0 tracks dut_a, index 1 tracks dut_b.
    bit     m_halt;
    longint m_hz[2], m_mdu[2], m_fl[2];
    int     m_run;
    bit     m_to[2];
    longint cmax[2];
    int     smax[2];

    function automatic logic [5:0] ctrl_a();
        return {if_a.PC_En, if_a.IFID_En, if_a.IFID_Flush, if_a.IDEX_En, if_a.IDEX_Flush, if_a.EXMEM_Flush};
    endfunction

    function automatic logic [5:0] ctrl_b();
        return {if_b.PC_En, if_b.IFID_En, if_b.IFID_Flush, if_b.IDEX_En, if_b.IDEX_Flush, if_b.EXMEM_Flush};
    endfunction

    function automatic logic [5:0] model_ctrl(bit hz, bit br, bit mdu, bit hr);
        if (m_halt || hr) return FRZ;
        if (mdu)          return MDU;
        if (hz)           return HZ;
        if (br)           return BR;
        return NORM;
    endfunction

    task automatic model_reset();
        m_halt = 0;
        m_run  = 0;
        for (int k = 0; k < 2; k++) begin
            m_hz[k] = 0; m_mdu[k] = 0; m_fl[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_step(bit hz, bit br, bit mdu, bit hr, bit rs);
        if (m_halt) begin
            if (rs) m_halt = 0;
        end else if (hr) begin
            m_halt = 1;
            m_run  = 0;
        end else if (mdu) begin
            for (int k = 0; k < 2; k++) if (m_mdu[k] < cmax[k]) m_mdu[k]++;
            m_run = 0;
        end else if (hz) begin
            m_run++;
            for (int k = 0; k < 2; k++) begin
                if (m_hz[k] < cmax[k]) m_hz[k]++;
                if (m_run >= smax[k]) m_to[k] = 1;
            end
        end else begin
            if (br) for (int k = 0; k < 2; k++) if (m_fl[k] < cmax[k]) m_fl[k]++;
            m_run = 0;
        end
    endtask

    task automatic set_in(bit hz, bit br, bit mdu, bit hr, bit rs);
        if_a.Hazard = hz; if_a.Branch_Taken = br; if_a.mdu_busy = mdu; if_a.halt_req = hr; if_a.resume = rs;
        if_b.Hazard = hz; if_b.Branch_Taken = br; if_b.mdu_busy = mdu; if_b.halt_req = hr; if_b.resume = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            checks++;
            if (ctrl_a() !== FRZ || ctrl_b() !== FRZ) begin
                errors++;
                $display("[TB] FAIL reset_ctrl: got a=%b b=%b expected %b", ctrl_a(), ctrl_b(), FRZ);
            end
            checks++;
            if (if_a.Halted !== 1'b0 || if_a.stall_timeout !== 1'b0 || if_a.hz_cnt !== 32'd0 ||
                if_a.mdu_cnt !== 32'd0 || if_a.flush_cnt !== 32'd0 || if_b.hz_cnt !== 4'd0) begin
                errors++;
                $display("[TB] FAIL reset_status: got halted=%b to=%b hz=%0d mdu=%0d fl=%0d expected all 0",
                         if_a.Halted, if_a.stall_timeout, if_a.hz_cnt, if_a.mdu_cnt, if_a.flush_cnt);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl_a() !== NORM) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b expected %b", ctrl_a(), NORM);
        end
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0);
            #1;
            checks++;
            if (ctrl_a() !== HZ) begin
                errors++;
                $display("[TB] FAIL hazard_ctrl cyc %0d: got %b expected %b", i, ctrl_a(), HZ);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (ctrl_a() !== NORM || if_a.hz_cnt !== 32'd3 || if_b.hz_cnt !== 4'd3) begin
            errors++;
            $display("[TB] FAIL hazard_after: got ctrl=%b hz_a=%0d hz_b=%0d expected %b 3 3",
                     ctrl_a(), if_a.hz_cnt, if_b.hz_cnt, NORM);
        end
        tick();
    endtask

    task automatic test_hazard_branch();
        do_reset();
        set_in(1, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl_a() !== HZ) begin
            errors++;
            $display("[TB] FAIL hz_br_ctrl: got %b expected %b", ctrl_a(), HZ);
        end
        tick();
        set_in(0, 1, 0, 0, 0);
        #1;
        checks++;
        if (ctrl_a() !== BR) begin
            errors++;
            $display("[TB] FAIL br_ctrl: got %b expected %b", ctrl_a(), BR);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (if_a.flush_cnt !== 32'd1 || if_a.hz_cnt !== 32'd1) begin
            errors++;
            $display("[TB] FAIL hz_br_counts: got flush=%0d hz=%0d expected 1 1", if_a.flush_cnt, if_a.hz_cnt);
        end
    endtask

    task automatic test_mdu();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 1, 0, 0);
            #1;
            checks++;
            if (ctrl_a() !== MDU || ctrl_b() !== MDU) begin
                errors++;
                $display("[TB] FAIL mdu_ctrl cyc %0d: got %b expected %b", i, ctrl_a(), MDU);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (if_a.mdu_cnt !== 32'd5 || if_a.hz_cnt !== 32'd0 || if_b.mdu_cnt !== 4'd5 || if_b.stall_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mdu_counts: got mdu=%0d hz=%0d to_b=%b expected 5 0 0",
                     if_a.mdu_cnt, if_a.hz_cnt, if_b.stall_timeout);
        end
    endtask

    task automatic test_halt();
        do_reset();
        set_in(0, 0, 0, 0, 1);
        #1;
        checks++;
        if (ctrl_a() !== NORM) begin
            errors++;
            $display("[TB] FAIL resume_in_run: got %b expected %b", ctrl_a(), NORM);
        end
        tick();
        set_in(1, 0, 0, 1, 0);
        #1;
        checks++;
        if (ctrl_a() !== FRZ || if_a.Halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL halt_req_cycle: got ctrl=%b halted=%b expected %b 0", ctrl_a(), if_a.Halted, FRZ);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 1, 1, 0);
            #1;
            checks++;
            if (ctrl_a() !== FRZ || if_a.Halted !== 1'b1) begin
                errors++;
                $display("[TB] FAIL halted_cyc %0d: got ctrl=%b halted=%b expected %b 1", i, ctrl_a(), if_a.Halted, FRZ);
            end
            tick();
        end
        set_in(0, 0, 0, 0, 1);
        #1;
        checks++;
        if (ctrl_a() !== FRZ || if_a.Halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resume_cycle: got ctrl=%b halted=%b expected %b 1", ctrl_a(), if_a.Halted, FRZ);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        #1;
        checks++;
        if (ctrl_a() !== NORM || if_a.Halted !== 1'b0 || if_a.hz_cnt !== 32'd0 || if_a.mdu_cnt !== 32'd0) begin
            errors++;
            $display("[TB] FAIL after_resume: got ctrl=%b halted=%b hz=%0d mdu=%0d expected %b 0 0 0",
                     ctrl_a(), if_a.Halted, if_a.hz_cnt, if_a.mdu_cnt, NORM);
        end
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0);
            tick();
            checks++;
            if (if_b.stall_timeout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wd_burst1 cyc %0d: got %b expected 0", i, if_b.stall_timeout);
            end
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0);
            tick();
            checks++;
            if (if_b.stall_timeout !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL wd_burst2 cyc %0d: got %b expected %b", i, if_b.stall_timeout, (i == 3));
            end
        end
        set_in(0, 1, 0, 0, 0);
        repeat (3) tick();
        set_in(0, 0, 0, 0, 0);
        checks++;
        if (if_b.stall_timeout !== 1'b1 || if_a.stall_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wd_sticky: got b=%b a=%b expected 1 0", if_b.stall_timeout, if_a.stall_timeout);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        repeat (20) tick();
        checks++;
        if (if_b.hz_cnt !== 4'd15 || if_a.hz_cnt !== 32'd20 || if_a.stall_timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL saturation: got hz_b=%0d hz_a=%0d to_a=%b expected 15 20 1",
                     if_b.hz_cnt, if_a.hz_cnt, if_a.stall_timeout);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctrl_b() !== FRZ || if_b.hz_cnt !== 4'd0 || if_b.stall_timeout !== 1'b0 || if_b.Halted !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall: got ctrl=%b hz=%0d to=%b halted=%b expected 0",
                     ctrl_b(), if_b.hz_cnt, if_b.stall_timeout, if_b.Halted);
        end
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++;
        if (if_a.Halted !== 1'b0 || ctrl_a() !== FRZ) begin
            errors++;
            $display("[TB] FAIL reset_mid_halt: got halted=%b ctrl=%b expected 0 %b", if_a.Halted, ctrl_a(), FRZ);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl_a() !== NORM) begin
            errors++;
            $display("[TB] FAIL run_after_reset: got %b expected %b", ctrl_a(), NORM);
        end
        tick();
    endtask

    task automatic test_random();
        bit hz, br, mdu, hr, rs;
        logic [5:0] exp_c;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hz  = ($urandom_range(99) < 55);
            br  = ($urandom_range(99) < 30);
            mdu = ($urandom_range(99) < 12);
            hr  = ($urandom_range(99) < 4);
            rs  = ($urandom_range(99) < 25);
            set_in(hz, br, mdu, hr, rs);
            #1;
            exp_c = model_ctrl(hz, br, mdu, hr);
            checks++;
            if (ctrl_a() !== exp_c || ctrl_b() !== exp_c) begin
                errors++;
                $display("[TB] FAIL rand_ctrl cyc %0d: got a=%b b=%b expected %b", i, ctrl_a(), ctrl_b(), exp_c);
            end
            tick();
            model_step(hz, br, mdu, hr, rs);
            checks++;
            if (if_a.Halted !== m_halt || if_a.hz_cnt !== m_hz[0][31:0] || if_a.mdu_cnt !== m_mdu[0][31:0] ||
                if_a.flush_cnt !== m_fl[0][31:0] || if_a.stall_timeout !== m_to[0]) begin
                errors++;
                $display("[TB] FAIL rand_status_a cyc %0d: got h=%b hz=%0d mdu=%0d fl=%0d to=%b expected %b %0d %0d %0d %b",
                         i, if_a.Halted, if_a.hz_cnt, if_a.mdu_cnt, if_a.flush_cnt, if_a.stall_timeout,
                         m_halt, m_hz[0], m_mdu[0], m_fl[0], m_to[0]);
            end
            checks++;
            if (if_b.Halted !== m_halt || if_b.hz_cnt !== m_hz[1][3:0] || if_b.mdu_cnt !== m_mdu[1][3:0] ||
                if_b.flush_cnt !== m_fl[1][3:0] || if_b.stall_timeout !== m_to[1]) begin
                errors++;
                $display("[TB] FAIL rand_status_b cyc %0d: got h=%b hz=%0d mdu=%0d fl=%0d to=%b expected %b %0d %0d %0d %b",
                         i, if_b.Halted, if_b.hz_cnt, if_b.mdu_cnt, if_b.flush_cnt, if_b.stall_timeout,
                         m_halt, m_hz[1], m_mdu[1], m_fl[1], m_to[1]);
            end
        end
    endtask

    initial begin
        cmax[0] = (64'd1 << 32) - 1;
        cmax[1] = 15;
        smax[0] = 16;
        smax[1] = 4;
        model_reset();
        test_reset();
        test_hazard();
        test_hazard_branch();
        test_mdu();
        test_halt();
        test_watchdog();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
